rgb_planar_to_gray: RTL and testbench

Parametrised front-end for the sobel_filter datapath. It accepts planar RGB beats (an R word, then a G word, then a B word, each LANES pixels wide) and emits one packed grayscale word per RGB triplet. The output selects luma, average, or single-channel pass-through. Unlike the first-generation valid-only stream, it has ready/valid backpressure on both sides, explicit start-of-triplet framing, and recovery from phase errors.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/rgb_lane_gray.sv | 36 +++
 rtl/rgb_planar_to_gray.sv | 114 +++++++++++
 tb/tb_rgb_planar_to_gray.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared enums and default parameters for the gray front-end
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_LUMA = 2'd0,
    MODE_AVG  = 2'd1,
    MODE_R    = 2'd2,
    MODE_G    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_R = 2'd0,
    S_G = 2'd1,
    S_B = 2'd2
  } phase_e;

  localparam int LANES_DEF = 16;
  localparam int PIX_W_DEF = 8;
  localparam int WR_DEF    = 77;
  localparam int WG_DEF    = 150;
  localparam int WB_DEF    = 29;

endpackage

// File: rtl/rgb_lane_gray.sv
// rtl/rgb_lane_gray.sv - combinational single-lane RGB to gray with saturation
module rgb_lane_gray
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int WR    = WR_DEF,
  parameter int WG    = WG_DEF,
  parameter int WB    = WB_DEF
) (
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  input  mode_e            mode,
  output logic [PIX_W-1:0] y
);

  localparam int SW = PIX_W + 10;

  logic [SW-1:0] luma_sum;
  logic [SW-1:0] avg_sum;
  logic [SW-1:0] sel;

  always_comb begin
    luma_sum = SW'(WR) * SW'(r) + SW'(WG) * SW'(g) + SW'(WB) * SW'(b) + SW'(128);
    avg_sum  = SW'(r) + (SW'(g) << 1) + SW'(b) + SW'(2);
    case (mode)
      MODE_LUMA: sel = luma_sum >> 8;
      MODE_AVG:  sel = avg_sum >> 2;
      MODE_R:    sel = SW'(r);
      default:   sel = SW'(g);
    endcase
    // Only reachable when the luma weights sum past 256.
    y = (|sel[SW-1:PIX_W]) ? {PIX_W{1'b1}} : sel[PIX_W-1:0];
  end

endmodule

// File: rtl/rgb_planar_to_gray.sv
// rtl/rgb_planar_to_gray.sv - planar RGB triplet framing FSM with ready/valid gray output
module rgb_planar_to_gray
  import sobel_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int WR    = WR_DEF,
  parameter int WG    = WG_DEF,
  parameter int WB    = WB_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*PIX_W-1:0] data_in,
  input  logic                   valid_in,
  input  logic                   sop_in,
  output logic                   ready_in,
  input  logic [1:0]             mode,
  output logic [LANES*PIX_W-1:0] data_out,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic                   phase_err,
  output logic [31:0]            triplet_cnt
);

  localparam int W = LANES * PIX_W;

  phase_e         state, state_nxt;
  mode_e          mode_q;
  logic [W-1:0]   r_buf, g_buf, gray;
  logic           accept, load_r, load_g, fire_b, frame_err;

  always_ff @(posedge clk) begin
    if (rst) state <= S_R;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_in  = 1'b1;
    load_r    = 1'b0;
    load_g    = 1'b0;
    fire_b    = 1'b0;
    frame_err = 1'b0;
    // The B beat may only land when the single output register is free or draining.
    if (state == S_B) ready_in = !valid_out || ready_out;
    accept = valid_in && ready_in;
    if (accept) begin
      if (sop_in) begin
        load_r    = 1'b1;
        frame_err = (state != S_R);
        state_nxt = S_G;
      end else begin
        case (state)
          S_R: begin
            load_r    = 1'b1;
            frame_err = 1'b1;
            state_nxt = S_G;
          end
          S_G: begin
            load_g    = 1'b1;
            state_nxt = S_B;
          end
          S_B: begin
            fire_b    = 1'b1;
            state_nxt = S_R;
          end
          default: state_nxt = S_R;
        endcase
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    rgb_lane_gray #(
      .PIX_W (PIX_W),
      .WR    (WR),
      .WG    (WG),
      .WB    (WB)
    ) u_lane (
      .r    (r_buf[PIX_W*j +: PIX_W]),
      .g    (g_buf[PIX_W*j +: PIX_W]),
      .b    (data_in[PIX_W*j +: PIX_W]),
      .mode (mode_q),
      .y    (gray[PIX_W*j +: PIX_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      g_buf       <= '0;
      mode_q      <= MODE_LUMA;
      data_out    <= '0;
      valid_out   <= 1'b0;
      phase_err   <= 1'b0;
      triplet_cnt <= '0;
    end else begin
      phase_err <= frame_err;
      if (load_r) begin
        r_buf  <= data_in;
        mode_q <= mode_e'(mode);
      end
      if (load_g) g_buf <= data_in;
      if (fire_b) begin
        data_out  <= gray;
        valid_out <= 1'b1;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
      if (valid_out && ready_out) triplet_cnt <= triplet_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rgb_planar_to_gray.sv
// tb/tb_rgb_planar_to_gray.sv - scoreboard bench for rgb_planar_to_gray
module tb_rgb_planar_to_gray;

  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic          sop_in;
  logic          ready_in;
  logic [1:0]    mode;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          ready_out;
  logic          phase_err;
  logic [31:0]   triplet_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  rgb_planar_to_gray dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .sop_in      (sop_in),
    .ready_in    (ready_in),
    .mode        (mode),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .phase_err   (phase_err),
    .triplet_cnt (triplet_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_word(input int lane, input logic [7:0] v);
    logic [W-1:0] w;
    w = '0;
    w[8*lane +: 8] = v;
    return w;
  endfunction

  // Caller sits just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [W-1:0] w, input logic sop);
    int n;
    data_in  = w;
    valid_in = 1'b1;
    sop_in   = sop;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", W'(ready_in), W'(1));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
  endtask

  task automatic triplet(input logic [W-1:0] rw, input logic [W-1:0] gw, input logic [W-1:0] bw,
                         input logic [1:0] m, input logic [W-1:0] exp);
    mode = m;
    send(rw, 1'b1);
    send(gw, 1'b0);
    exp_q.push_back(exp);
    send(bw, 1'b0);
  endtask

  task automatic drain(input string name, input logic [31:0] exp_cnt);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_out) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 50) chk({name, "_drain_timeout"}, W'(exp_q.size()), W'(0));
    chk({name, "_triplet_cnt"}, W'(triplet_cnt), W'(exp_cnt));
  endtask

  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", data_out, '0);
        if (data_out === '0) begin
          errors++;
          $display("FAIL unexpected_output actual=valid required=idle");
        end
      end else begin
        chk("scoreboard_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] r0, g0, b0, r15, g15, b15, ones, junk;

  initial begin
    r0   = lane_word(0, 8'd100);
    g0   = lane_word(0, 8'd50);
    b0   = lane_word(0, 8'd200);
    r15  = lane_word(15, 8'd10);
    g15  = lane_word(15, 8'd20);
    b15  = lane_word(15, 8'd30);
    ones = {W{1'b1}};
    junk = {16{8'h5A}};

    rst = 1'b1; data_in = '0; valid_in = 1'b0; sop_in = 1'b0; mode = 2'd0; ready_out = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid_out", W'(valid_out), W'(0));
    chk("reset_data_out", data_out, '0);
    chk("reset_phase_err", W'(phase_err), W'(0));
    chk("reset_triplet_cnt", W'(triplet_cnt), W'(0));
    chk("reset_ready_in", W'(ready_in), W'(1));
    @(posedge clk); #1;

    ready_out = 1'b1;
    triplet(ones, ones, ones, 2'd0, ones);
    chk("latency_valid_out", W'(valid_out), W'(1));
    drain("white", 32'd1);

    triplet(r0, g0, b0, 2'd0, lane_word(0, 8'd82));
    triplet(r0, g0, b0, 2'd1, lane_word(0, 8'd100));
    triplet(r0, g0, b0, 2'd2, lane_word(0, 8'd100));
    triplet(r0, g0, b0, 2'd3, lane_word(0, 8'd50));
    drain("modes", 32'd5);

    ready_out = 1'b0;
    triplet(r0, g0, b0, 2'd0, lane_word(0, 8'd82));
    mode = 2'd1;
    send(r15, 1'b1);
    send(g15, 1'b0);
    @(negedge clk);
    chk("stall_ready_in", W'(ready_in), W'(0));
    chk("stall_hold_data", data_out, lane_word(0, 8'd82));
    chk("stall_hold_valid", W'(valid_out), W'(1));
    @(posedge clk); #1;
    ready_out = 1'b1;
    exp_q.push_back(lane_word(15, 8'd20));
    send(b15, 1'b0);
    triplet(r0, g0, b0, 2'd3, lane_word(0, 8'd50));
    triplet(r15, g15, b15, 2'd0, lane_word(15, 8'd18));
    drain("stall", 32'd9);

    mode = 2'd1;
    send(r15, 1'b0);
    chk("no_sop_phase_err", W'(phase_err), W'(1));
    send(g15, 1'b0);
    chk("no_sop_phase_err_clear", W'(phase_err), W'(0));
    exp_q.push_back(lane_word(15, 8'd20));
    send(b15, 1'b0);
    drain("resync", 32'd10);

    mode = 2'd0;
    send(junk, 1'b1);
    send(r0, 1'b1);
    chk("mid_sop_phase_err", W'(phase_err), W'(1));
    send(g0, 1'b0);
    chk("mid_sop_phase_err_once", W'(phase_err), W'(0));
    exp_q.push_back(lane_word(0, 8'd82));
    send(b0, 1'b0);
    drain("mid_sop", 32'd11);

    send(junk, 1'b1);
    send(junk, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_valid_out", W'(valid_out), W'(0));
    chk("midreset_triplet_cnt", W'(triplet_cnt), W'(0));
    triplet(r15, g15, b15, 2'd1, lane_word(15, 8'd20));
    drain("after_reset", 32'd1);

    mode = 2'd0;
    send(r0, 1'b1);
    send(g0, 1'b0);
    mode = 2'd1;
    exp_q.push_back(lane_word(0, 8'd82));
    send(b0, 1'b0);
    drain("mode_latch", 32'd2);

    chk("queue_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
